mmio_stream_q: RTL
==================

Name: mmio_stream_q

Overview:
- Parametrised successor to the team's single-register MMIO test block. Keeps the same 4-byte-addressed wr/rd bus.
- Input writes are buffered in a FIFO and passed through a LAT-stage add pipeline. Results are queued in an output FIFO and popped by reads.
- Adds status and error reporting so software can exercise real producer/consumer HW/SW handshakes in simulation.

Parameters:
BASE, 16'hBEEF, value addr_in[31:16] must equal to select the block
DEPTH, 8, entries in each FIFO (2..255)
LAT, 2, pipeline stages between input-FIFO pop and output-FIFO push (1..8)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
addr_in  in  32  byte address
data_in  in  32  write data
wr_in  in  1  write strobe, one access per cycle
rd_in  in  1  read strobe
rd_valid_out  out  1  registered copy of rd_in
data_out  out  32  read data, valid while rd_valid_out=1

Behaviour:
- Select: sel = (addr_in[31:16]==BASE). Offsets not listed below: writes ignored, reads return 0.
- Read timing: rd_valid_out <= rd_in every cycle, regardless of sel. Selected reads load data_out one cycle after the strobe. data_out holds its value when no selected read occurs.
- Reset values: data_out=0, rd_valid_out=0, CONFIG=0, both FIFOs empty, pipeline valid bits 0, sticky flags 0, PROC_COUNT=0. Reset mid-operation flushes all in-flight data.
- Register map:
  - 0x00 CONFIG (RW): [0] en; [31:16] addend.
  - 0x04 IN_DATA (W): push data_in to the input FIFO. If full, the write is dropped and OVF is set. Reads return 0.
  - 0x08 OUT_DATA (R): pop the output FIFO and return its head. If empty, return 0, leave FIFO state unchanged, set UNF.
  - 0x0C STATUS (R; write-1-to-clear bits [4] and [5]): [0] in_empty, [1] in_full, [2] out_empty, [3] out_full, [4] OVF, [5] UNF, [15:8] out_count, [23:16] in_count, [31:24] inflight.
  - 0x10 PROC_COUNT (R): results pushed to the output FIFO, 32-bit, wraps 0xFFFFFFFF -> 0.
- Issue rule: pop the input FIFO into stage 1 when all of the following hold:
  - en=1;
  - input FIFO not empty;
  - out_count + inflight < DEPTH.
  - This guarantees the output FIFO never overflows. Throughput is at most one item per cycle.
- Datapath: result = data + {16'h0, addend}, mod 2^32. The addend is sampled at issue.
- Latency: an IN_DATA write at cycle t (en=1, everything empty) is readable from OUT_DATA at a read strobe of cycle t+LAT+2. Breakdown: FIFO write t, issue t+1, stages t+1..t+LAT, output push at end of t+LAT+1.
- Pipeline: advances unconditionally. No stall is needed because of the issue rule.
- Disabling: clearing en stops issue only. Items already in flight drain to the output FIFO.
- FIFO pointers wrap modulo DEPTH. Counts are $clog2(DEPTH+1) bits, zero-extended into the STATUS fields.
- Simultaneous events:
  - Push to a full input FIFO in the same cycle as an issue pop: accepted, no OVF, count unchanged.
  - Output push and OUT_DATA pop in the same cycle: both take effect; an empty FIFO returns 0 with UNF (no bypass).
  - wr_in and rd_in in the same cycle both act on addr_in.
  - W1C on a sticky bit in the same cycle as a new set event: set wins.
- STATUS reads reflect register state at the strobe edge, before that cycle's updates.

Optional Feature:
- Macro: MMIO_STREAM_Q_IRQ_EN.
- When defined:
  - Adds port irq_out (out, 1; reset 0).
  - CONFIG gains [1] irq_en and [15:8] thresh.
  - irq_out registered: irq_out <= irq_en & ((out_count >= thresh and thresh != 0) | OVF | UNF).
- When undefined:
  - No irq_out port.
  - CONFIG[15:1] read back 0 and ignore writes.

Test Plan:
- Reset, then write CONFIG=0x002A0001, write IN_DATA=0x10 -> OUT_DATA read returns 0x3A at earliest cycle t+LAT+2; PROC_COUNT=1; STATUS[2]=1 after the pop.
- en=0, write 9 items with DEPTH=8 -> in_count=8, in_full=1, OVF=1. Write STATUS=0x10 -> OVF=0.
- en=1, fill with 8 items, no reads -> out_count=8, out_full=1, inflight=0. Input FIFO drains no further; read all 8 in order, values data+addend.
- Read OUT_DATA while empty -> data_out=0, rd_valid_out=1 next cycle, UNF=1. Read offset 0x20 -> 0 with no flag.
- Assert rst with 3 items in flight -> all counts 0, data_out=0, no output push afterward.
- With MMIO_STREAM_Q_IRQ_EN: thresh=2, irq_en=1, push 2 items -> irq_out rises one cycle after out_count reaches 2; pop 1 -> irq_out falls.

Source files
------------

// File: rtl/mmio_stream_q.sv
// MMIO-fed add pipeline: IN_DATA writes queue into an input FIFO, pass a LAT-stage adder and
// land in an output FIFO popped by OUT_DATA reads. Optional IRQ via MMIO_STREAM_Q_IRQ_EN.
module mmio_stream_q #(
   parameter logic [15:0] BASE  = 16'hBEEF,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned LAT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_in,
   input  logic [31:0] data_in,
   input  logic        wr_in,
   input  logic        rd_in,
   output logic        rd_valid_out,
   output logic [31:0] data_out
`ifdef MMIO_STREAM_Q_IRQ_EN
   ,
   output logic        irq_out
`endif
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [15:0] OffConfig = 16'h0000;
   localparam logic [15:0] OffInData = 16'h0004;
   localparam logic [15:0] OffOutData = 16'h0008;
   localparam logic [15:0] OffStatus = 16'h000C;
   localparam logic [15:0] OffProcCount = 16'h0010;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Bus decode
   logic        sel;
   logic [15:0] off;
   logic        wr_config;
   logic        wr_in_data;
   logic        wr_status;
   logic        rd_out_data;

   assign sel         = (addr_in[31:16] == BASE);
   assign off         = addr_in[15:0];
   assign wr_config   = wr_in & sel & (off == OffConfig);
   assign wr_in_data  = wr_in & sel & (off == OffInData);
   assign wr_status   = wr_in & sel & (off == OffStatus);
   assign rd_out_data = rd_in & sel & (off == OffOutData);

   // Configuration and status state
   logic        en_q;
   logic [15:0] addend_q;
   logic        ovf_q;
   logic        unf_q;
   logic [31:0] proc_count_q;
`ifdef MMIO_STREAM_Q_IRQ_EN
   logic        irq_en_q;
   logic [7:0]  thresh_q;
`endif

   // FIFO state
   logic [31:0]   in_mem [DEPTH];
   logic [PW-1:0] in_wptr_q;
   logic [PW-1:0] in_rptr_q;
   logic [CW-1:0] in_count_q;
   logic [31:0]   out_mem [DEPTH];
   logic [PW-1:0] out_wptr_q;
   logic [PW-1:0] out_rptr_q;
   logic [CW-1:0] out_count_q;

   // Pipeline state
   logic [LAT-1:0] vld_q;
   logic [31:0]    dat_q [LAT];

   logic       in_empty;
   logic       in_full;
   logic       out_empty;
   logic       out_full;
   logic [7:0] inflight;
   logic [9:0] occupancy;
   logic       issue;
   logic       in_push;
   logic       out_push;
   logic       out_pop;
   logic       ovf_set;
   logic       unf_set;

   assign in_empty  = (in_count_q == '0);
   assign in_full   = (in_count_q == CW'(DEPTH));
   assign out_empty = (out_count_q == '0);
   assign out_full  = (out_count_q == CW'(DEPTH));

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + 8'(vld_q[i]);
      end
   end

   // Reserving output space for everything in flight means the pipeline never has to stall.
   assign occupancy = 10'(out_count_q) + 10'(inflight);
   assign issue     = en_q & ~in_empty & (occupancy < 10'(DEPTH));

   // A full input FIFO still accepts a write when the same cycle pops it.
   assign in_push  = wr_in_data & (~in_full | issue);
   assign ovf_set  = wr_in_data & in_full & ~issue;
   assign out_push = vld_q[LAT-1];
   assign out_pop  = rd_out_data & ~out_empty;
   assign unf_set  = rd_out_data & out_empty;

   // Register readback
   logic [31:0] config_rd;
   logic [31:0] status_rd;
   logic [31:0] rdata;

`ifdef MMIO_STREAM_Q_IRQ_EN
   assign config_rd = {addend_q, thresh_q, 6'h0, irq_en_q, en_q};
`else
   assign config_rd = {addend_q, 15'h0, en_q};
`endif

   assign status_rd = {inflight, 8'(in_count_q), 8'(out_count_q), 2'b00,
                       unf_q, ovf_q, out_full, out_empty, in_full, in_empty};

   always_comb begin
      rdata = '0;
      case (off)
         OffConfig:    rdata = config_rd;
         OffOutData:   rdata = out_empty ? 32'h0 : out_mem[out_rptr_q];
         OffStatus:    rdata = status_rd;
         OffProcCount: rdata = proc_count_q;
         default:      rdata = '0;
      endcase
   end

   // Storage without reset: contents are only observed through the valid counts.
   always_ff @(posedge clk) begin
      if (in_push) in_mem[in_wptr_q] <= data_in;
      if (out_push) out_mem[out_wptr_q] <= dat_q[LAT-1];
      dat_q[0] <= in_mem[in_rptr_q] + {16'h0, addend_q};
      for (int i = 1; i < LAT; i++) begin
         dat_q[i] <= dat_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q         <= 1'b0;
         addend_q     <= '0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         proc_count_q <= '0;
         in_wptr_q    <= '0;
         in_rptr_q    <= '0;
         in_count_q   <= '0;
         out_wptr_q   <= '0;
         out_rptr_q   <= '0;
         out_count_q  <= '0;
         vld_q        <= '0;
         rd_valid_out <= 1'b0;
         data_out     <= '0;
      end else begin
         if (wr_config) begin
            en_q     <= data_in[0];
            addend_q <= data_in[31:16];
         end

         ovf_q <= ovf_set | (ovf_q & ~(wr_status & data_in[4]));
         unf_q <= unf_set | (unf_q & ~(wr_status & data_in[5]));

         if (in_push) in_wptr_q <= ptr_next(in_wptr_q);
         if (issue) in_rptr_q <= ptr_next(in_rptr_q);
         if (in_push && !issue) in_count_q <= in_count_q + CW'(1);
         else if (!in_push && issue) in_count_q <= in_count_q - CW'(1);

         vld_q[0] <= issue;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
         end

         if (out_push) begin
            out_wptr_q   <= ptr_next(out_wptr_q);
            proc_count_q <= proc_count_q + 32'd1;
         end
         if (out_pop) out_rptr_q <= ptr_next(out_rptr_q);
         if (out_push && !out_pop) out_count_q <= out_count_q + CW'(1);
         else if (!out_push && out_pop) out_count_q <= out_count_q - CW'(1);

         rd_valid_out <= rd_in;
         if (rd_in && sel) data_out <= rdata;
      end
   end

`ifdef MMIO_STREAM_Q_IRQ_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q <= 1'b0;
         thresh_q <= '0;
         irq_out  <= 1'b0;
      end else begin
         if (wr_config) begin
            irq_en_q <= data_in[1];
            thresh_q <= data_in[15:8];
         end
         irq_out <= irq_en_q &
                    (((8'(out_count_q) >= thresh_q) && (thresh_q != 8'h0)) | ovf_q | unf_q);
      end
   end
`endif

endmodule
